// File: rtl/feeder_pkg.sv
// Shared definitions for the operand feeder; the FLUSH state only exists
// when FEEDER_ZERO_FLUSH_EN is defined.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
`ifdef FEEDER_ZERO_FLUSH_EN
        ,
        FLUSH  = 2'd2
`endif
    } feeder_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Vector FIFO: N lanes of DATA_WIDTH bits, DEPTH entries (power of 2, >= 2).
// No bypass: a pushed vector becomes visible at the read port one cycle later.
module vec_fifo
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data [N-1:0],
    output logic [DATA_WIDTH-1:0] rd_data [N-1:0],
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = N * DATA_WIDTH;

    logic [VW-1:0] mem [DEPTH];
    logic [VW-1:0] wr_flat;
    logic [VW-1:0] rd_flat;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_flat = mem[rd_ptr_reg[AW-1:0]];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign wr_flat[gi*DATA_WIDTH +: DATA_WIDTH] = wr_data[gi];
            assign rd_data[gi] = rd_flat[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_flat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Buffers operand vectors and streams k_len of them per tile into the skew stage.
// FEEDER_ZERO_FLUSH_EN appends N-1 all-zero beats to drain the array.
module operand_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int DEPTH      = 4,
    parameter int K_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [N-1:0],
    output logic                  out_en,
    output logic [DATA_WIDTH-1:0] out_data [N-1:0],
    output logic                  busy,
    output logic                  done
);

`ifdef FEEDER_ZERO_FLUSH_EN
    localparam int FW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? (N - 2) : 0);
    logic [FW-1:0] flush_cnt_reg;
`endif

    feeder_state_e         state_reg;
    logic [K_WIDTH-1:0]    k_len_reg;
    logic [K_WIDTH-1:0]    beat_cnt_reg;
    logic                  ready_en_reg;
    logic                  out_en_reg;
    logic                  done_reg;
    logic [DATA_WIDTH-1:0] out_data_reg [N-1:0];
    logic [DATA_WIDTH-1:0] fifo_rd [N-1:0];
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  last_pop;

    // ready_en_reg keeps in_ready low through reset and the edge that releases it.
    assign in_ready  = ready_en_reg && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_reg == STREAM) && !fifo_empty;
    assign last_pop  = fifo_pop && ((beat_cnt_reg + K_WIDTH'(1)) == k_len_reg);
    assign busy      = (state_reg != IDLE);
    assign out_en    = out_en_reg;
    assign done      = done_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign out_data[gi] = out_data_reg[gi];
        end
    endgenerate

    vec_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            k_len_reg    <= '0;
            beat_cnt_reg <= '0;
            ready_en_reg <= 1'b0;
            out_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
`ifdef FEEDER_ZERO_FLUSH_EN
            flush_cnt_reg <= '0;
`endif
            for (int i = 0; i < N; i++) begin
                out_data_reg[i] <= '0;
            end
        end else begin
            ready_en_reg <= 1'b1;
            out_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (k_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            k_len_reg    <= k_len;
                            beat_cnt_reg <= '0;
                            state_reg    <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    // An empty FIFO leaves out_data untouched so the skew stage freezes.
                    if (fifo_pop) begin
                        out_en_reg   <= 1'b1;
                        out_data_reg <= fifo_rd;
                        beat_cnt_reg <= beat_cnt_reg + K_WIDTH'(1);
                        if (last_pop) begin
`ifdef FEEDER_ZERO_FLUSH_EN
                            if (N > 1) begin
                                state_reg     <= FLUSH;
                                flush_cnt_reg <= '0;
                            end else begin
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end
`else
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FEEDER_ZERO_FLUSH_EN
                FLUSH: begin
                    out_en_reg    <= 1'b1;
                    flush_cnt_reg <= flush_cnt_reg + FW'(1);
                    for (int i = 0; i < N; i++) begin
                        out_data_reg[i] <= '0;
                    end
                    if (flush_cnt_reg == FLUSH_LAST) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder (N=4, DEPTH=4): stimulus queues expected
// beats, a negedge monitor pops and compares whenever out_en or done is seen.
module tb_operand_feeder;

    localparam int DW    = 16;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int KW    = 16;
    localparam int FW    = DW * N;
`ifdef FEEDER_ZERO_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    typedef struct packed {
        logic          en;
        logic          dn;
        logic [FW-1:0] data;
    } exp_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic [KW-1:0] k_len    = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_en;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data  [N-1:0];
    logic [DW-1:0] out_data [N-1:0];

    exp_t          exp_q  [$];
    logic [FW-1:0] tile_q [$];
    int            checks = 0;
    int            errors = 0;
    int            beat_no = 0;
    logic [FW-1:0] last_data = '0;

    always #5 clk = ~clk;

    operand_feeder #(
        .DATA_WIDTH (DW),
        .N          (N),
        .DEPTH      (DEPTH),
        .K_WIDTH    (KW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_en   (out_en),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    // Lane l of a test vector holds base + l.
    function automatic logic [FW-1:0] mkvec(input logic [DW-1:0] base);
        logic [FW-1:0] r;
        for (int l = 0; l < N; l++) r[l*DW +: DW] = base + DW'(l);
        return r;
    endfunction

    function automatic logic [FW-1:0] flat_out();
        logic [FW-1:0] r;
        for (int l = 0; l < N; l++) r[l*DW +: DW] = out_data[l];
        return r;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [FW-1:0] v);
        for (int l = 0; l < N; l++) in_data[l] = v[l*DW +: DW];
    endtask

    task automatic push_vec(input logic [FW-1:0] v);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        set_in(v);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 20 cycles, expected acceptance");
        end
    endtask

    task automatic start_tile(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
    endtask

    // Queue the data beats held in tile_q, then the flush beats if enabled.
    task automatic exp_tile();
        int n;
        n = tile_q.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back('{en: 1'b1, dn: (!FLUSH_ON && i == n - 1), data: tile_q[i]});
        if (FLUSH_ON)
            for (int j = 0; j < N - 1; j++)
                exp_q.push_back('{en: 1'b1, dn: (j == N - 2), data: '0});
        tile_q.delete();
    endtask

    task automatic wait_done(input string name, input int exp_gaps);
        bit seen;
        bit fin;
        int gaps;
        seen = 1'b0;
        fin  = 1'b0;
        gaps = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk);
            if (out_en) seen = 1'b1;
            else if (seen && !done) gaps++;
            if (done) fin = 1'b1;
        end
        check({name, "_done_seen"}, FW'(fin), FW'(1));
        check({name, "_stall_gaps"}, FW'(gaps), FW'(exp_gaps));
        check({name, "_busy_at_done"}, FW'(busy), FW'(0));
    endtask

    // Monitor: one line per issued beat or done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_data = '0;
        end else begin
            if (out_en || done) begin
                beat_no++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got out_en=%0b done=%0b data=%0h, expected no activity",
                             out_en, done, flat_out());
                end else begin
                    e = exp_q.pop_front();
                    check("beat_en", FW'(out_en), FW'(e.en));
                    check("beat_done", FW'(done), FW'(e.dn));
                    if (e.en) check("beat_data", flat_out(), e.data);
                    $display("beat %0d: out_en=%0b done=%0b data=%h", beat_no, out_en, done, flat_out());
                end
            end
            if (!out_en) check("hold_data", flat_out(), last_data);
            else last_data = flat_out();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        for (int l = 0; l < N; l++) in_data[l] = '0;

        // Reset and idle
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", FW'(in_ready), FW'(0));
        check("rst_out_en", FW'(out_en), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_done", FW'(done), FW'(0));
        check("rst_out_data", flat_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", FW'(in_ready), FW'(1));
        check("post_rst_out_en", FW'(out_en), FW'(0));
        check("post_rst_out_data", flat_out(), '0);

        // Three preloaded vectors, k_len = 3
        push_vec(mkvec(16'h0100));
        push_vec(mkvec(16'h0200));
        push_vec(mkvec(16'h0300));
        check("preload_in_ready", FW'(in_ready), FW'(1));
        tile_q.push_back(mkvec(16'h0100));
        tile_q.push_back(mkvec(16'h0200));
        tile_q.push_back(mkvec(16'h0300));
        exp_tile();
        start_tile(3);
        wait_done("k3", 0);
        tick();

        // k_len = 5 with in_valid low for two cycles mid-tile
        for (int i = 0; i < 5; i++) tile_q.push_back(mkvec(DW'(16'h1000 + 16'h0100 * i)));
        exp_tile();
        start = 1'b1;
        k_len = KW'(5);
        in_valid = 1'b1;
        set_in(mkvec(16'h1000));
        fork
            begin
                tick();
                start = 1'b0;
                set_in(mkvec(16'h1100));
                tick();
                in_valid = 1'b0;
                tick();
                tick();
                push_vec(mkvec(16'h1200));
                push_vec(mkvec(16'h1300));
                push_vec(mkvec(16'h1400));
            end
            wait_done("stall", 2);
        join
        tick();

        // Full FIFO with start and a pending fifth vector
        for (int i = 0; i < 4; i++) push_vec(mkvec(DW'(16'h2000 + 16'h0100 * i)));
        check("full_in_ready", FW'(in_ready), FW'(0));
        for (int i = 0; i < 4; i++) tile_q.push_back(mkvec(DW'(16'h2000 + 16'h0100 * i)));
        exp_tile();
        start = 1'b1;
        k_len = KW'(4);
        in_valid = 1'b1;
        set_in(mkvec(16'h2400));
        fork
            begin
                @(negedge clk);
                check("full_start_in_ready", FW'(in_ready), FW'(0));
                tick();
                start = 1'b0;
                @(negedge clk);
                check("pop_cycle_in_ready", FW'(in_ready), FW'(0));
                tick();
                @(negedge clk);
                check("after_pop_in_ready", FW'(in_ready), FW'(1));
                tick();
                in_valid = 1'b0;
            end
            wait_done("full", 0);
        join
        tick();
        tile_q.push_back(mkvec(16'h2400));
        exp_tile();
        start_tile(1);
        wait_done("leftover", 0);
        tick();

        // k_len = 0
        exp_q.push_back('{en: 1'b0, dn: 1'b1, data: '0});
        start_tile(0);
        @(negedge clk);
        check("k0_done", FW'(done), FW'(1));
        check("k0_busy", FW'(busy), FW'(0));
        check("k0_out_en", FW'(out_en), FW'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("k0_quiet_out_en", FW'(out_en), FW'(0));
            check("k0_quiet_busy", FW'(busy), FW'(0));
        end
        tick();

        // Reset on beat 2 of a k_len = 4 tile
        for (int i = 0; i < 4; i++) push_vec(mkvec(DW'(16'h3000 + 16'h0100 * i)));
        for (int i = 0; i < 4; i++) tile_q.push_back(mkvec(DW'(16'h3000 + 16'h0100 * i)));
        exp_tile();
        start_tile(4);
        nb = 0;
        for (int i = 0; i < 30 && nb < 2; i++) begin
            @(negedge clk);
            if (out_en) nb++;
        end
        check("rst_mid_reached_beat2", FW'(nb), FW'(2));
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_out_en", FW'(out_en), FW'(0));
        check("rst_mid_busy", FW'(busy), FW'(0));
        check("rst_mid_done", FW'(done), FW'(0));
        check("rst_mid_in_ready", FW'(in_ready), FW'(0));
        check("rst_mid_out_data", flat_out(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_mid_ready_back", FW'(in_ready), FW'(1));
        repeat (3) tick();
        push_vec(mkvec(16'h4000));
        push_vec(mkvec(16'h4100));
        tile_q.push_back(mkvec(16'h4000));
        tile_q.push_back(mkvec(16'h4100));
        exp_tile();
        start_tile(2);
        wait_done("after_rst", 0);
        repeat (4) tick();

        check("scoreboard_drained", FW'(exp_q.size()), FW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
